cordic_iter_ctrl: RTL and testbench
===================================

// Module: cordic_iter_ctrl
// PURPOSE
//  Sequencer for the bit-serial CORDIC datapath (x/y/z shift-register slices).
//  Issues one load cycle and then N_ITER iterations. For each iteration it drives:
//  - iteration index, shift selects and add/sub ops;
//  - the per-iteration start level.
//  Waits for every slice's done flag before advancing. Sits between the top-level
//  command interface and the three datapath slices.
// PARAMETERS
//  N_ITER   16    iterations per operation (1..16); equals the datapath word width
//  TIMEOUT  64    max cycles in RUN waiting for all slice dones before err
// PORTS
//  clk       in   1  rising-edge clock, single clock domain
//  rst_n     in   1  synchronous active-low reset
//  go        in   1  request new operation; sampled in IDLE only
//  mode      in   1  0 = rotation (steer on z sign), 1 = vectoring (steer on y sign); sampled with go
//  ysign     in   1  MSB of y slice register
//  zsign     in   1  MSB of z slice register
//  xdone     in   1  x slice finished current iteration
//  ydone     in   1  y slice finished current iteration
//  zdone     in   1  z slice finished current iteration
//  i         out  5  to slices: 0 = load initial values, 1..N_ITER = iteration k+1
//  start     out  1  to slices: high = shift/accumulate, low = hold and clear bit counter
//  selx      out  4  x slice tap = shift amount k (feeds y update)
//  sely      out  4  y slice tap = shift amount k (feeds x update)
//  atan_addr out  4  arctan ROM address = k
//  op_x      out  1  1 = subtract in x update
//  op_y      out  1  1 = subtract in y update
//  op_z      out  1  1 = subtract in z update
//  busy      out  1  high from go acceptance until DONE exits
//  done      out  1  one-cycle pulse, result valid in slices
//  err       out  1  sticky timeout flag; cleared by next accepted go or reset
// BEHAVIOUR
//  Reset values (rst_n=0 at posedge):
//  - state=IDLE; i=0, start=0, sel*/atan_addr=0, op_*=0.
//  - busy=0, done=0, err=0, k=0, mode_r=0, s_r=0.
//  FSM states and transitions:
//  - IDLE: go=1 -> LOAD; latch mode_r, clear err.
//  - LOAD: exactly 1 cycle; i=0, start=0. -> SETUP with k=0.
//  - SETUP: exactly 1 cycle.
//    - i=k+1, start=0, so slice counters clear.
//    - Latch s_r = mode_r ? ~ysign : zsign.
//    - Drive selx=sely=atan_addr=k. -> RUN.
//  - RUN: start=1; i, sel*, op_* held constant.
//    - Stays until xdone&ydone&zdone all sampled 1 in the same cycle.
//    - Then -> NEXT.
//  - NEXT: exactly 1 cycle; start=0.
//    - If k==N_ITER-1 -> DONE; else k<=k+1 -> SETUP.
//  - DONE: 1 cycle; done=1, busy=0 from the following cycle. -> IDLE.
//  Direction:
//  - d=+1 when s_r=0.
//  - op_x = ~s_r, op_y = s_r, op_z = ~s_r.
//  - op_* are registered from s_r and valid from the first RUN cycle.
//  Result hold:
//  - In IDLE after an operation, i keeps last value (N_ITER) and start=0.
//  - This keeps the slices holding results. Only reset drives i=0 in IDLE.
//  Latency:
//  - Per iteration: 2 + T_run cycles, where T_run = RUN cycles.
//  - With slices asserting done 17 cycles after start, each iteration costs 19 cycles.
//  - go to done pulse = 1 + 19*N_ITER + 1 = 306 cycles for N_ITER=16.
//  Boundary rules:
//  - go while busy: ignored, with no queueing.
//  - go held high: a new operation starts on the cycle after DONE returns to IDLE.
//  - Dones are level-sensitive and need not rise together; sample the AND only.
//  - Timeout: a per-RUN cycle counter reaching TIMEOUT forces err=1 and jumps to DONE.
//    - done still pulses; err stays set.
//  - Reset mid-operation: returns to IDLE at that edge with all reset values.
//    - Any partial result is discarded.
//  - sign inputs are ignored outside SETUP.
// TESTING
//  - Reset: assert rst_n=0 for 2 clk in RUN -> next cycle IDLE, i=0, start=0, busy=0, done=0.
//  - Rotation: mode=0, zsign=0 every SETUP, dones at 17 cycles.
//    -> op_x=1, op_y=0, op_z=1.
//    -> i steps 0,1..16 and selx steps 0..15.
//    -> done pulses 306 cycles after go.
//  - Vectoring: mode=1, ysign toggles each iteration.
//    -> op_y equals ~ysign sampled in the matching SETUP.
//    -> zsign changes are ignored.
//  - Skewed dones: xdone at 17, ydone at 20, zdone at 18 cycles.
//    -> NEXT entered only the cycle after the 20th.
//  - Timeout: hold zdone=0 -> after 64 RUN cycles err=1 and done pulses.
//    -> next go clears err.
//  - go pulsed during RUN -> ignored; a single done; i stays 16 in IDLE with start=0.

Source files
------------

// File: rtl/cordic_iter_ctrl_if.sv
// Command/slice bundle for the bit-serial CORDIC iteration sequencer.
//   master: the sequencer. It takes go/mode, slice signs and slice dones, and drives
//           the iteration index, start, taps, ROM address, add/sub ops and status.
//   slave : the environment. It is the top-level command side plus the x/y/z slices.
interface cordic_iter_ctrl_if;
   logic       go;
   logic       mode;
   logic       ysign;
   logic       zsign;
   logic       xdone;
   logic       ydone;
   logic       zdone;
   logic [4:0] i;
   logic       start;
   logic [3:0] selx;
   logic [3:0] sely;
   logic [3:0] atan_addr;
   logic       op_x;
   logic       op_y;
   logic       op_z;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      input  go, mode, ysign, zsign, xdone, ydone, zdone,
      output i, start, selx, sely, atan_addr, op_x, op_y, op_z, busy, done, err
   );

   modport slave (
      output go, mode, ysign, zsign, xdone, ydone, zdone,
      input  i, start, selx, sely, atan_addr, op_x, op_y, op_z, busy, done, err
   );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the bit-serial CORDIC slices: one load cycle, then N_ITER iterations.
// Latency: go to done = 1 + N_ITER*(2 + T_run) + 1 cycles. T_run is the number of RUN cycles.
// Backpressure: waits in RUN until all three slice dones are high together, or until TIMEOUT.
// Ports: clk, rst_n (synchronous, active low), bus (master modport: go/mode/signs/dones in;
//        i/start/selx/sely/atan_addr/op_x/op_y/op_z/busy/done/err out).
module cordic_iter_ctrl #(
   parameter int N_ITER  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   cordic_iter_ctrl_if.master  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETUP, S_RUN, S_NEXT, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      k_q, k_d;
   logic            mode_q, mode_d;
   logic            s_q, s_d;
   logic [4:0]      i_q, i_d;
   logic [3:0]      sel_q, sel_d;
   logic [2:0]      op_q, op_d;      // {op_x, op_y, op_z}
   logic            err_q, err_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            all_done;

   // Slice dones are levels that may rise at different times.
   // Only the cycle in which all three are high counts.
   assign all_done = bus.xdone & bus.ydone & bus.zdone;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      mode_d  = mode_q;
      s_d     = s_q;
      i_d     = i_q;
      sel_d   = sel_q;
      op_d    = op_q;
      err_d   = err_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         S_IDLE: begin
            // i is not cleared on return to IDLE, so the slices keep the result.
            if (bus.go) begin
               state_d = S_LOAD;
               mode_d  = bus.mode;
               err_d   = 1'b0;
               i_d     = 5'd0;
            end
         end
         S_LOAD: begin
            state_d = S_SETUP;
            k_d     = 4'd0;
            i_d     = 5'd1;
            sel_d   = 4'd0;
         end
         S_SETUP: begin
            // The sign is sampled only here. Ops are registered, so they are
            // stable for the whole RUN phase.
            s_d     = mode_q ? ~bus.ysign : bus.zsign;
            op_d    = {~s_d, s_d, ~s_d};
            tcnt_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (all_done) begin
               state_d = S_NEXT;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tcnt_d  = tcnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            if (k_q == 4'(N_ITER - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SETUP;
               k_d     = k_q + 4'd1;
               i_d     = {1'b0, k_q} + 5'd2;
               sel_d   = k_q + 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         mode_q  <= 1'b0;
         s_q     <= 1'b0;
         i_q     <= '0;
         sel_q   <= '0;
         op_q    <= '0;
         err_q   <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         s_q     <= s_d;
         i_q     <= i_d;
         sel_q   <= sel_d;
         op_q    <= op_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign bus.i         = i_q;
   assign bus.start     = (state_q == S_RUN);
   assign bus.selx      = sel_q;
   assign bus.sely      = sel_q;
   assign bus.atan_addr = sel_q;
   assign bus.op_x      = op_q[2];
   assign bus.op_y      = op_q[1];
   assign bus.op_z      = op_q[0];
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: table of whole operations plus hand-written reset/go-held sequences.
// Slice model: each slice raises done N start-cycles after start rises; N=0 means never.
// Ports: none (top-level bench).
module tb_cordic_iter_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cordic_iter_ctrl_if ifc ();

   cordic_iter_ctrl #(.N_ITER(16), .TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct {
      logic mode;    // operation mode
      logic zs;      // constant zsign used in rotation
      int   xd, yd, zd;
      bit   gorun;   // pulse go during RUN
      int   lat;     // go cycle to done cycle
      bit   err;
      int   iters;
      int   runlen;  // RUN cycles per iteration
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic cfg_mode = 1'b0;
   logic cfg_zs = 1'b0;
   int   xd = 17, yd = 17, zd = 17;

   // Slice model: counts start-high cycles; ysign follows the iteration parity in vectoring.
   int cnt = 0;
   int itn = 0;
   bit pstart = 1'b0;
   always @(negedge clk) begin
      if (!rst_n || !ifc.start) cnt = 0;
      else                      cnt = cnt + 1;
      if (!ifc.busy)                  itn = 0;
      else if (pstart && !ifc.start)  itn = itn + 1;
      pstart = ifc.start;
      ifc.xdone = ifc.start && (xd != 0) && (cnt >= xd);
      ifc.ydone = ifc.start && (yd != 0) && (cnt >= yd);
      ifc.zdone = ifc.start && (zd != 0) && (cnt >= zd);
      if (cfg_mode) begin
         ifc.ysign = itn[0];
         ifc.zsign = 1'($urandom_range(0, 1));
      end else begin
         ifc.ysign = 1'($urandom_range(0, 1));
         ifc.zsign = cfg_zs;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_idle_reset();
      check("rst_i", ifc.i, 0);
      check("rst_start", ifc.start, 0);
      check("rst_busy", ifc.busy, 0);
      check("rst_done", ifc.done, 0);
      check("rst_err", ifc.err, 0);
      check("rst_ops", {ifc.op_x, ifc.op_y, ifc.op_z}, 0);
      check("rst_sel", {ifc.selx, ifc.sely, ifc.atan_addr}, 0);
   endtask

   task automatic run_op(input vec_t v);
      int   cyc, n, runlen;
      bit   pst, got;
      logic s;
      cfg_mode = v.mode; cfg_zs = v.zs; xd = v.xd; yd = v.yd; zd = v.zd;
      @(negedge clk);
      ifc.go = 1'b1; ifc.mode = v.mode;
      cyc = 0; n = 0; runlen = 0; pst = 1'b0; got = 1'b0;
      while (!got && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         ifc.go = v.gorun && ifc.start && (cyc % 50 == 0);
         if (cyc == 1) begin
            ifc.mode = ~v.mode;   // mode must have been latched at go
            check("load_i", ifc.i, 0);
            check("load_busy", ifc.busy, 1);
            check("load_start", ifc.start, 0);
            check("load_err", ifc.err, 0);
         end
         if (ifc.start && !pst) begin
            s = v.mode ? ~n[0] : v.zs;
            check("run_i", ifc.i, n + 1);
            check("run_selx", ifc.selx, n);
            check("run_sely_atan", {ifc.sely, ifc.atan_addr}, {n[3:0], n[3:0]});
            check("run_ops", {ifc.op_x, ifc.op_y, ifc.op_z}, {~s, s, ~s});
            runlen = 1;
         end else if (ifc.start) begin
            runlen++;
         end
         if (!ifc.start && pst) begin
            check("run_len", runlen, v.runlen);
            n++;
         end
         pst = ifc.start;
         if (ifc.done) begin
            got = 1'b1;
            check("latency", cyc, v.lat);
            check("done_err", ifc.err, v.err);
         end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL done_wait: got no done within %0d cycles, expected at %0d", cyc, v.lat);
      end
      check("iterations", n, v.iters);
      repeat (3) begin
         @(negedge clk);
         check("idle_state", {ifc.busy, ifc.done, ifc.start}, 0);
         check("idle_hold_i", ifc.i, v.iters);
         check("idle_err", ifc.err, v.err);
      end
   endtask

   vec_t vt[6];
   int   cyc;
   bit   seen;

   initial begin
      //           mode  zs    xd  yd  zd  gorun lat  err iters runlen
      vt[0] = '{1'b0, 1'b0, 17, 17, 17, 1'b0, 306, 1'b0, 16, 17};   // rotation
      vt[1] = '{1'b0, 1'b1, 17, 17, 17, 1'b0, 306, 1'b0, 16, 17};   // rotation, negative z
      vt[2] = '{1'b1, 1'b0, 17, 17, 17, 1'b0, 306, 1'b0, 16, 17};   // vectoring
      vt[3] = '{1'b0, 1'b0, 17, 20, 18, 1'b0, 354, 1'b0, 16, 20};   // skewed dones
      vt[4] = '{1'b0, 1'b0, 17, 17,  0, 1'b0,  67, 1'b1,  1, 64};   // timeout
      vt[5] = '{1'b0, 1'b0, 17, 17, 17, 1'b1, 306, 1'b0, 16, 17};   // go during RUN

      rst_n = 1'b0; ifc.go = 1'b0; ifc.mode = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_reset();
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run_op(vt[t]);

      // Reset mid-RUN discards the operation.
      cfg_mode = 1'b0; cfg_zs = 1'b0; xd = 17; yd = 17; zd = 17;
      @(negedge clk);
      ifc.go = 1'b1;
      cyc = 0;
      @(negedge clk);
      ifc.go = 1'b0;
      while (!ifc.start && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_run", ifc.start, 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_reset();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.done || ifc.busy) seen = 1'b1;
      end
      check("no_activity_after_rst", seen, 0);

      // go held high restarts on the cycle after DONE returns to IDLE.
      @(negedge clk);
      ifc.go = 1'b1;
      cyc = 0;
      while (!ifc.done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("held_latency", cyc, 306);
      @(negedge clk);
      check("held_idle_busy", ifc.busy, 0);
      check("held_idle_i", ifc.i, 16);
      @(negedge clk);
      check("held_restart_busy", ifc.busy, 1);
      check("held_restart_i", ifc.i, 0);
      ifc.go = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
